// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-to-hazard-controller signal bundle.
// The pipeline side drives stage register fields; the controller side returns stall/flush/forward controls.
interface hazard_ctrl_if;
    logic [4:0]  id_rs1, id_rs2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_regwrite;
    logic [1:0]  ex_result_src;
    logic        ex_pc_src;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwrite, wb_regwrite;
    logic        dmem_req, dmem_ack;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_w;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic        mem_err;
    logic [15:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_result_src, ex_pc_src,
               mem_rd, wb_rd, mem_regwrite, wb_regwrite, dmem_req, dmem_ack,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               fwd_a_e, fwd_b_e, mem_err, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_result_src, ex_pc_src,
               mem_rd, wb_rd, mem_regwrite, wb_regwrite, dmem_req, dmem_ack,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               fwd_a_e, fwd_b_e, mem_err, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline hazard controller (load-use, branch flush, dmem wait/timeout,
// post-reset flush, forwarding selects, saturating stall-cycle counter).
module hazard_ctrl #(
    parameter int INIT_CYCLES = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {INIT, RUN, MWAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, wait_n;
    logic        err_q, err_d, blk_q, blk_d;
    logic [15:0] sc_q, sc_d;
    logic        run, mw, lw;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= INIT;
            cnt_q   <= 8'(INIT_CYCLES - 1);
            err_q   <= 1'b0;
            blk_q   <= 1'b0;
            sc_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            blk_q   <= blk_d;
            sc_q    <= sc_d;
        end

    always_comb begin
        run     = state_q != INIT;
        // blk_q masks a still-high request after a timeout until it has dropped for a cycle
        mw      = run && hz.dmem_req && !hz.dmem_ack && !blk_q;
        lw      = hz.ex_result_src == 2'b01 && hz.ex_regwrite && hz.ex_rd != 5'd0 &&
                  (hz.ex_rd == hz.id_rs1 || hz.ex_rd == hz.id_rs2);
        wait_n  = state_q == MWAIT ? cnt_q + 8'd1 : 8'd1;
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        blk_d   = blk_q && hz.dmem_req;
        hz.stall_f = 1'b0;
        hz.stall_d = 1'b0;
        hz.stall_e = 1'b0;
        hz.stall_m = 1'b0;
        hz.flush_d = 1'b0;
        hz.flush_e = 1'b0;
        hz.flush_w = 1'b0;
        hz.fwd_a_e = !run ? 2'b00 :
                     (hz.mem_regwrite && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs1) ? 2'b10 :
                     (hz.wb_regwrite && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs1) ? 2'b01 : 2'b00;
        hz.fwd_b_e = !run ? 2'b00 :
                     (hz.mem_regwrite && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs2) ? 2'b10 :
                     (hz.wb_regwrite && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs2) ? 2'b01 : 2'b00;
        if (!run) begin
            hz.stall_f = 1'b1;
            hz.flush_d = 1'b1;
            hz.flush_e = 1'b1;
            hz.flush_w = 1'b1;
            cnt_d      = cnt_q - 8'd1;
            state_d    = cnt_q == 8'd0 ? RUN : INIT;
        end else if (mw) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.stall_e = 1'b1;
            hz.stall_m = 1'b1;
            hz.flush_w = 1'b1;
            cnt_d      = wait_n;
            state_d    = MWAIT;
            if (wait_n == 8'(MEM_TIMEOUT)) begin
                err_d   = 1'b1;
                blk_d   = 1'b1;
                state_d = RUN;
            end
        end else begin
            hz.stall_f = lw && !hz.ex_pc_src;
            hz.stall_d = lw && !hz.ex_pc_src;
            hz.flush_d = hz.ex_pc_src;
            hz.flush_e = lw || hz.ex_pc_src;
            state_d    = RUN;
        end
        sc_d = (hz.stall_f && sc_q != 16'hFFFF) ? sc_q + 16'd1 : sc_q;
    end

    assign hz.mem_err      = err_q;
    assign hz.stall_cycles = sc_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus with a cycle-level reference model checked on every negedge,
// plus hand-computed literal expectations along the test sequence.
module tb_hazard_ctrl;
    localparam int IC = 3;
    localparam int TO = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_left = 0, m_waited = 0, m_stalls = 0;
    logic m_err = 1'b0, m_block = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl_if hz();
    hazard_ctrl #(.INIT_CYCLES(IC), .MEM_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .hz(hz));

    function automatic logic [6:0] ctl();
        return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e, hz.flush_w};
    endfunction

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (hz.mem_regwrite && hz.mem_rd != 0 && hz.mem_rd == rs) return 2'b10;
        if (hz.wb_regwrite && hz.wb_rd != 0 && hz.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Model: outputs for this cycle from current inputs, then advance across the coming edge.
    always @(negedge clk) begin : model
        logic [6:0] ctl_e;
        logic [1:0] fa_e, fb_e;
        logic       mwc, lwc, br;
        logic [27:0] got_v, exp_v;
        mwc = 1'b0;
        if (!reset) begin
            m_left = IC; m_waited = 0; m_stalls = 0; m_err = 1'b0; m_block = 1'b0;
            ctl_e = 7'b1000111; fa_e = 2'b00; fb_e = 2'b00;
        end else if (m_left > 0) begin
            ctl_e = 7'b1000111; fa_e = 2'b00; fb_e = 2'b00;
        end else begin
            fa_e = fwd_ref(hz.ex_rs1);
            fb_e = fwd_ref(hz.ex_rs2);
            mwc  = hz.dmem_req && !hz.dmem_ack && !m_block;
            lwc  = hz.ex_result_src == 2'b01 && hz.ex_regwrite && hz.ex_rd != 0 &&
                   (hz.ex_rd == hz.id_rs1 || hz.ex_rd == hz.id_rs2);
            br   = hz.ex_pc_src;
            ctl_e = mwc ? 7'b1111001 : {lwc && !br, lwc && !br, 2'b00, br, lwc || br, 1'b0};
        end
        exp_v = {ctl_e, fa_e, fb_e, m_err, 16'(m_stalls)};
        got_v = {ctl(), hz.fwd_a_e, hz.fwd_b_e, hz.mem_err, hz.stall_cycles};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got ctl=%b fwd=%b/%b err=%b sc=%0d expected ctl=%b fwd=%b/%b err=%b sc=%0d",
                     $time, got_v[27:21], got_v[20:19], got_v[18:17], got_v[16], got_v[15:0],
                     ctl_e, fa_e, fb_e, m_err, m_stalls);
        end
        if (reset) begin
            if (ctl_e[6] && m_stalls < 65535) m_stalls++;
            if (m_left > 0) m_left--;
            else begin
                m_block = m_block && hz.dmem_req;
                if (mwc) begin
                    m_waited++;
                    if (m_waited >= TO) begin
                        m_err = 1'b1; m_block = 1'b1; m_waited = 0;
                    end
                end else m_waited = 0;
            end
        end
    end

    initial begin
        hz.id_rs1 = 0; hz.id_rs2 = 0; hz.ex_rs1 = 0; hz.ex_rs2 = 0; hz.ex_rd = 0;
        hz.ex_regwrite = 0; hz.ex_result_src = 0; hz.ex_pc_src = 0;
        hz.mem_rd = 0; hz.wb_rd = 0; hz.mem_regwrite = 0; hz.wb_regwrite = 0;
        hz.dmem_req = 0; hz.dmem_ack = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        lit("rst_ctl", 32'(ctl()), 'b1000111);
        lit("rst_cnt", 32'({hz.mem_err, hz.stall_cycles}), 0);
        lit("rst_fwd", 32'({hz.fwd_a_e, hz.fwd_b_e}), 0);
        nxt(); reset = 1;
        repeat (IC) begin
            @(negedge clk);
            lit("init_hold", 32'(ctl()), 'b1000111);
        end
        @(negedge clk);
        lit("init_done", 32'(ctl()), 0);
        lit("init_cnt", 32'(hz.stall_cycles), 3);
        nxt();
        hz.ex_rs1 = 5; hz.ex_rs2 = 5; hz.mem_rd = 5; hz.wb_rd = 5; hz.mem_regwrite = 1; hz.wb_regwrite = 1;
        @(negedge clk); lit("fwd_mem", 32'({hz.fwd_a_e, hz.fwd_b_e}), 'b1010);
        nxt(); hz.mem_regwrite = 0;
        @(negedge clk); lit("fwd_wb", 32'({hz.fwd_a_e, hz.fwd_b_e}), 'b0101);
        nxt(); hz.mem_regwrite = 1; hz.mem_rd = 0; hz.wb_rd = 0;
        @(negedge clk); lit("fwd_x0", 32'({hz.fwd_a_e, hz.fwd_b_e}), 0);
        nxt(); hz.mem_rd = 5; hz.wb_rd = 9; hz.ex_rs2 = 9;
        @(negedge clk); lit("fwd_mix", 32'({hz.fwd_a_e, hz.fwd_b_e}), 'b1001);
        nxt(); hz.mem_regwrite = 0; hz.wb_regwrite = 0;
        hz.ex_result_src = 1; hz.ex_regwrite = 1; hz.ex_rd = 7; hz.id_rs2 = 7;
        @(negedge clk); lit("lu_stall", 32'(ctl()), 'b1100010);
        nxt(); hz.ex_result_src = 0;
        @(negedge clk); lit("lu_gone", 32'(ctl()), 0);
        nxt(); hz.ex_result_src = 1; hz.ex_pc_src = 1;
        @(negedge clk); lit("lu_br", 32'(ctl()), 'b0000110);
        nxt(); hz.ex_pc_src = 0; hz.ex_rd = 0; hz.id_rs1 = 0; hz.id_rs2 = 0;
        @(negedge clk); lit("lu_x0", 32'(ctl()), 0); lit("lu_cnt", 32'(hz.stall_cycles), 4);
        nxt(); hz.ex_result_src = 0; hz.ex_regwrite = 0;
        hz.dmem_req = 1; hz.ex_pc_src = 1;
        repeat (4) begin
            @(negedge clk); lit("mw_stall", 32'(ctl()), 'b1111001);
            nxt();
        end
        hz.dmem_ack = 1;
        @(negedge clk); lit("mw_ack", 32'(ctl()), 'b0000110);
        nxt(); hz.dmem_req = 0; hz.dmem_ack = 0; hz.ex_pc_src = 0;
        @(negedge clk); lit("mw_cnt", 32'(hz.stall_cycles), 8);
        nxt(); hz.dmem_req = 1;
        repeat (TO) begin
            @(negedge clk); lit("to_stall", 32'(ctl()), 'b1111001); lit("to_err0", 32'(hz.mem_err), 0);
            nxt();
        end
        repeat (2) begin
            @(negedge clk); lit("to_rel", 32'(ctl()), 0); lit("to_err", 32'(hz.mem_err), 1);
            nxt();
        end
        hz.dmem_req = 0;
        @(negedge clk); lit("to_low", 32'(ctl()), 0);
        nxt(); hz.dmem_req = 1;
        @(negedge clk); lit("to_rearm", 32'(ctl()), 'b1111001);
        nxt(); hz.dmem_ack = 1;
        @(negedge clk); lit("to_ack", 32'(ctl()), 0); lit("to_cnt", 32'(hz.stall_cycles), 14);
        nxt(); hz.dmem_ack = 0;
        @(negedge clk); lit("mr_wait", 32'(ctl()), 'b1111001);
        nxt(); reset = 0;
        #1;
        lit("mr_ctl", 32'(ctl()), 'b1000111);
        lit("mr_cnt", 32'({hz.mem_err, hz.stall_cycles}), 0);
        hz.dmem_req = 0;
        nxt(); reset = 1;
        repeat (IC + 1) nxt();
        hz.ex_rs1 = 9; hz.mem_rd = 9; hz.mem_regwrite = 1; hz.wb_rd = 9; hz.wb_regwrite = 1;
        @(negedge clk); lit("post_rst", 32'({hz.fwd_a_e, hz.mem_err}), 'b100);
        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
